// File: rtl/bcd_scan_converter.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per cycle) that then
// scans the BCD digits out MSB first, holding each for 2^DWELL_POW2 cycles.
module bcd_scan_converter #(
  parameter int WIDTH      = 8,
  parameter int DIGITS     = 3,
  parameter int DWELL_POW2 = 3,
  localparam int PW        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] binary,
  input  logic             blank_lz,
  output logic [3:0]       digit,
  output logic [PW-1:0]    digit_place,
  output logic             digit_valid,
  output logic             digit_blank,
  output logic             overflow
);

  localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW   = (DWELL_POW2 > 0) ? DWELL_POW2 : 1;
  localparam int BCDW = 4 * DIGITS;
  localparam logic [BW-1:0] LAST_BIT   = BW'(WIDTH - 1);
  localparam logic [PW-1:0] MSD_PLACE  = PW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, SCAN} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shift_q;
  logic [BCDW-1:0]   bcd_q;
  logic [BCDW-1:0]   bcd_adj;
  logic [BW-1:0]     bit_cnt_q;
  logic [DW-1:0]     dwell_q;
  logic [PW-1:0]     place_q;
  logic              ovf_q;
  logic              blank_en_q;
  logic              convert_last;
  logic              dwell_last;
  logic [3:0]        cur_nib;
  logic              upper_zero;

  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  assign convert_last = (bit_cnt_q == LAST_BIT);
  assign dwell_last   = (DWELL_POW2 == 0) || (dwell_q == '1);

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);
    end
  end

  // Current nibble plus "this and every more-significant nibble is zero"
  always_comb begin
    cur_nib    = 4'd0;
    upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (PW'(i) == place_q) cur_nib = bcd_q[4*i +: 4];
      if ((PW'(i) >= place_q) && (bcd_q[4*i +: 4] != 4'd0)) upper_zero = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CONVERT;
      CONVERT: if (convert_last) state_d = SCAN;
      SCAN:    if (dwell_last && (place_q == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      shift_q    <= '0;
      bcd_q      <= '0;
      bit_cnt_q  <= '0;
      dwell_q    <= '0;
      place_q    <= MSD_PLACE;
      ovf_q      <= 1'b0;
      blank_en_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            shift_q    <= binary;
            blank_en_q <= blank_lz;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            bit_cnt_q  <= '0;
            dwell_q    <= '0;
            place_q    <= MSD_PLACE;
          end
        end
        // Adjust, then shift the next binary bit in; a bit leaving the top nibble means overflow
        CONVERT: begin
          bcd_q     <= {bcd_adj[BCDW-2:0], shift_q[WIDTH-1]};
          shift_q   <= shift_q << 1;
          bit_cnt_q <= convert_last ? '0 : bit_cnt_q + BW'(1);
          if (bcd_adj[BCDW-1]) ovf_q <= 1'b1;
        end
        SCAN: begin
          dwell_q <= dwell_q + DW'(1);
          if (dwell_last) begin
            dwell_q <= '0;
            if (place_q != '0) place_q <= place_q - PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign digit_valid = (state_q == SCAN);
  assign digit       = ovf_q ? 4'hF : cur_nib;
  assign digit_place = place_q;
  assign overflow    = ovf_q;
  assign digit_blank = (state_q == SCAN) && blank_en_q && !ovf_q &&
                       (place_q != '0) && upper_zero;

endmodule
